// File: rtl/servo_pkg.sv
// Shared defaults and types for the servo PWM generator.
package servo_pkg;

   localparam int CLK_PER_US   = 100;
   localparam int FRAME_US     = 20000;
   localparam int PULSE_MIN_US = 500;
   localparam int POS_MAX      = 2000;
   localparam int POS_CENTER   = 1000;

   typedef logic [11:0] width_us_t;
   typedef logic [14:0] us_cnt_t;

endpackage

// File: rtl/servo_us_tick.sv
// Microsecond prescaler: tick is high on the last clock cycle of every microsecond.
module servo_us_tick #(
   parameter int CLK_PER_US = servo_pkg::CLK_PER_US
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

   logic [PRE_W-1:0] pre;

   assign tick = (pre == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (tick) begin
         pre <= '0;
      end else begin
         pre <= pre + PRE_W'(1);
      end
   end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator; position updates are applied only at frame boundaries.
// Define SERVO_PWM_SLEW_EN to limit the width change to SLEW_US per frame.
module servo_pwm_gen #(
   parameter int CLK_PER_US   = servo_pkg::CLK_PER_US,
   parameter int FRAME_US     = servo_pkg::FRAME_US,
   parameter int PULSE_MIN_US = servo_pkg::PULSE_MIN_US,
   parameter int POS_MAX      = servo_pkg::POS_MAX,
   parameter int POS_CENTER   = servo_pkg::POS_CENTER
`ifdef SERVO_PWM_SLEW_EN
   ,
   parameter int SLEW_US      = 20
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] pos,
   input  logic        pos_valid,
   output logic        pwm_out,
   output logic        frame_start,
   output logic [11:0] width_us
);

   import servo_pkg::*;

   localparam width_us_t WIDTH_RST = width_us_t'(PULSE_MIN_US + POS_CENTER);
   localparam width_us_t POS_LIM   = width_us_t'(POS_MAX);
   localparam width_us_t PULSE_MIN = width_us_t'(PULSE_MIN_US);
   localparam us_cnt_t   US_LAST   = us_cnt_t'(FRAME_US - 1);

   logic      tick;
   logic      wrap;
   us_cnt_t   us_cnt;
   width_us_t pending_us;
   width_us_t width_nxt;

   servo_us_tick #(
      .CLK_PER_US(CLK_PER_US)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   // Clamp before the add so the sum always fits in 12 bits.
   function automatic width_us_t pos_to_width(input logic [11:0] p);
      width_us_t lim;
      lim = (p > POS_LIM) ? POS_LIM : p;
      return PULSE_MIN + lim;
   endfunction

`ifdef SERVO_PWM_SLEW_EN
   function automatic width_us_t slew_step(input width_us_t cur, input width_us_t tgt);
      logic signed [12:0] diff;
      logic signed [12:0] lim;
      lim  = $signed(13'(SLEW_US));
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if (diff > lim) begin
         diff = lim;
      end else if (diff < -lim) begin
         diff = -lim;
      end
      return width_us_t'($signed({1'b0, cur}) + diff);
   endfunction
`endif

   assign wrap = tick && (us_cnt == US_LAST);

   always_comb begin
`ifdef SERVO_PWM_SLEW_EN
      width_nxt = slew_step(width_us, pending_us);
`else
      width_nxt = pending_us;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         us_cnt <= '0;
      end else if (tick) begin
         us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + us_cnt_t'(1);
      end
   end

   // A strobe on the wrap cycle only lands in pending; width picks it up next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_us <= WIDTH_RST;
         width_us   <= WIDTH_RST;
      end else begin
         if (pos_valid) begin
            pending_us <= pos_to_width(pos);
         end
         if (wrap) begin
            width_us <= width_nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_out     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pwm_out     <= (us_cnt < us_cnt_t'(width_us));
         frame_start <= wrap;
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: frame-level reference model, directed scenarios and random strobes.
module tb_servo_pwm_gen;

   localparam int CLKP  = 4;
   localparam int FR    = 64;
   localparam int PMIN  = 8;
   localparam int PMAX  = 40;
   localparam int CENT  = 20;
   localparam int SLEW  = 3;
   localparam int F     = FR * CLKP;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] pos;
   logic        pos_valid;
   logic        pwm_out;
   logic        frame_start;
   logic [11:0] width_us;

   int checks = 0;
   int errors = 0;

   servo_pwm_gen #(
      .CLK_PER_US  (CLKP),
      .FRAME_US    (FR),
      .PULSE_MIN_US(PMIN),
      .POS_MAX     (PMAX),
      .POS_CENTER  (CENT)
`ifdef SERVO_PWM_SLEW_EN
      ,
      .SLEW_US     (SLEW)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pos        (pos),
      .pos_valid  (pos_valid),
      .pwm_out    (pwm_out),
      .frame_start(frame_start),
      .width_us   (width_us)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int width_of(input int p);
      return PMIN + ((p > PMAX) ? PMAX : p);
   endfunction

   function automatic int next_width(input int cur, input int tgt);
      int d;
      d = tgt - cur;
`ifdef SERVO_PWM_SLEW_EN
      if (d > SLEW) d = SLEW;
      if (d < -SLEW) d = -SLEW;
`endif
      return cur + d;
   endfunction

   // Reference model: k counts clock edges since reset release; frames are F edges long.
   int k;
   int pend_m;
   int wid_m;
   int wprev;
   int exp_fs;
   int exp_pwm;
   int cap_v;
   int cap_pos;
   int prev_rst_low;
   int hi_run;
   int last_pulse;
   int first_fs;

   always @(negedge clk) begin
      if (!rst_n) begin
         k            = 0;
         pend_m       = PMIN + CENT;
         wid_m        = PMIN + CENT;
         cap_v        = 0;
         prev_rst_low = 1;
         hi_run       = 0;
         last_pulse   = -1;
         first_fs     = -1;
         chk("rst_pwm", int'(pwm_out), 0);
         chk("rst_fs", int'(frame_start), 0);
         chk("rst_width", int'(width_us), wid_m);
      end else begin
         if (prev_rst_low != 0) begin
            prev_rst_low = 0;
            chk("rel_pwm", int'(pwm_out), 0);
            chk("rel_width", int'(width_us), wid_m);
         end else begin
            k++;
            wprev  = wid_m;
            exp_fs = ((k % F) == 0) ? 1 : 0;
            if (exp_fs != 0) wid_m = next_width(wid_m, pend_m);
            if (cap_v != 0) pend_m = width_of(cap_pos);
            exp_pwm = (((k - 1) % F) < wprev * CLKP) ? 1 : 0;
            chk("pwm", int'(pwm_out), exp_pwm);
            chk("frame_start", int'(frame_start), exp_fs);
            chk("width", int'(width_us), wid_m);
            if (pwm_out) begin
               hi_run++;
            end else if (hi_run > 0) begin
               last_pulse = hi_run;
               hi_run     = 0;
            end
            if (frame_start && first_fs < 0) first_fs = k;
         end
         cap_v   = int'(pos_valid);
         cap_pos = int'(pos);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_fs();
      int i;
      i = 0;
      step(1);
      while (!frame_start && i < 2 * F) begin
         step(1);
         i++;
      end
      chk("wait_frame_start", int'(frame_start), 1);
   endtask

   task automatic strobe(input int p, input int len);
      pos       = 12'(p);
      pos_valid = 1'b1;
      step(len);
      pos_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int sel;
      rst_n     = 1'b0;
      pos       = '0;
      pos_valid = 1'b0;
      step(3);
      chk("lit_rst_width", int'(width_us), 28);
      rst_n = 1'b1;

      wait_fs();
      step(1);
      chk("lit_first_fs_edge", first_fs, 256);
      chk("lit_pulse_center", last_pulse, 112);

`ifndef SERVO_PWM_SLEW_EN
      step(100);
      strobe(0, 1);
      chk("lit_frame1_width", int'(width_us), 28);
      wait_fs();
      chk("lit_pos0_width", int'(width_us), 8);
      wait_fs();
      step(1);
      chk("lit_pos0_pulse", last_pulse, 32);

      step(50);
      strobe(4095, 3);
      wait_fs();
      chk("lit_pos4095_width", int'(width_us), 48);
      wait_fs();
      step(1);
      chk("lit_pos4095_pulse", last_pulse, 192);

      step(10);
      strobe(10, 1);
      step(20);
      strobe(30, 1);
      wait_fs();
      chk("lit_last_wins", int'(width_us), 38);

      step(F - 1);
      strobe(40, 1);
      chk("lit_wrap_fs", int'(frame_start), 1);
      chk("lit_wrap_old_width", int'(width_us), 38);
      wait_fs();
      chk("lit_wrap_applied_next", int'(width_us), 48);
`else
      step(20);
      strobe(PMAX, 1);
      wait_fs();
      chk("lit_slew_f2", int'(width_us), 31);
      wait_fs();
      chk("lit_slew_f3", int'(width_us), 34);
      wait_fs();
      chk("lit_slew_f4", int'(width_us), 37);
`endif

      for (int fr = 0; fr < 40; fr++) begin
         for (int c = 0; c < F; c++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
               0:       pos = 12'($urandom_range(0, 4095));
               1:       pos = 12'($urandom_range(0, 60));
               2:       pos = 12'($urandom_range(PMAX, PMAX + 1));
               default: pos = 12'd4095;
            endcase
            pos_valid = ($urandom_range(0, 24) == 0);
            step(1);
         end
      end
      pos_valid = 1'b0;

      wait_fs();
      strobe(PMAX, 1);
      step(28);
      chk("lit_pre_reset_pwm", int'(pwm_out), 1);
      rst_n = 1'b0;
      #1;
      chk("lit_async_pwm", int'(pwm_out), 0);
      chk("lit_async_width", int'(width_us), 28);
      step(2);
      rst_n = 1'b1;
      wait_fs();
      step(1);
      chk("lit_post_reset_fs_edge", first_fs, 256);
      chk("lit_post_reset_pulse", last_pulse, 112);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo pulse generator: consumes a 12-bit position word from the position source (ramp counter or SPI front end) and produces a standard hobby-servo PWM frame. Position updates are accepted at any time but applied only at frame boundaries, so no pulse is ever truncated or stretched mid-frame. Sits between the position source and the top-level servo output pin.

## Interface
- CLK_PER_US, 100, clock cycles per microsecond tick (100 MHz clock)
- FRAME_US, 20000, frame period in microseconds
- PULSE_MIN_US, 500, pulse width for position 0
- POS_MAX, 2000, positions above this are clamped to it
- POS_CENTER, 1000, position loaded at reset
- SLEW_US, 20, max width change per frame (only with slew feature)

- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- pos  in  12  requested position, unsigned
- pos_valid  in  1  single-cycle or held strobe; pos sampled every cycle it is high
- pwm_out  out  1  servo pulse, registered
- frame_start  out  1  one-cycle pulse marking the first cycle of each frame
- width_us  out  12  pulse width currently being generated, in microseconds

## Operation
- Block is always ready; no back-pressure.
- Prescaler `pre` counts 0..CLK_PER_US-1; `tick` = (pre == CLK_PER_US-1), wraps to 0.
- Microsecond counter `us_cnt` (15 bits) increments on tick, wraps FRAME_US-1 -> 0 on tick.
- Pending register: on pos_valid, pending_us <= PULSE_MIN_US + min(pos, POS_MAX). Last valid before a wrap wins.
- Frame wrap edge (tick with us_cnt == FRAME_US-1): width_us <= pending_us as it was before that edge. A pos_valid on the wrap cycle updates pending only; it applies next frame.
- pwm_out <= (us_cnt < width_us), evaluated on current register values each cycle.
- frame_start <= wrap condition; high exactly one cycle, coincident with us_cnt == 0 and pre == 0.
- Width arithmetic: 12-bit unsigned; max PULSE_MIN_US+POS_MAX = 2500 fits; clamp before add.

## Timing
- Reset (async assert): pre=0, us_cnt=0, pending_us=width_us=PULSE_MIN_US+POS_CENTER (1500), pwm_out=0, frame_start=0.
- First frame starts at reset release; pwm_out goes high on the first clk edge after release (one-cycle register latency); no frame_start for this first frame.
- Pulse high for width_us*CLK_PER_US cycles per frame; frame is FRAME_US*CLK_PER_US cycles (2 000 000 default).
- pos_valid to pwm_out effect: takes effect at next frame wrap; latency 1 cycle to a full frame.
- Reset asserted mid-frame: all state returns to reset values immediately; pwm_out drops asynchronously.
- pos > POS_MAX (e.g. 4095): width 2500 us, never wider.

## Configuration
- SERVO_PWM_SLEW_EN defined: at each wrap, width_us moves toward pending_us by at most SLEW_US (width_us += clamp(pending_us - width_us, -SLEW_US, +SLEW_US)); signed 13-bit difference. Reset still loads center width directly.
- Undefined: width_us <= pending_us directly at wrap; SLEW_US unused.

## Structure
- Package servo_pkg: CLK_PER_US, FRAME_US, PULSE_MIN_US, POS_MAX, POS_CENTER defaults; typedefs width_us_t (12-bit) and us_cnt_t (15-bit). Module parameters default to the package values.
- One sub-module: servo_us_tick (prescaler, outputs tick; async active-low reset).

## Test plan
- Reset release, no pos_valid -> pwm_out high 150 000 cycles, low 1 850 000, first frame_start at cycle 2 000 000 after release.
- pos=0 strobed mid-frame 1 -> frame 1 unchanged at 1500 us; frame 2 pulse 50 000 cycles, width_us=500.
- pos=4095 -> next frame width_us=2500, pulse 250 000 cycles.
- pos=200 then pos=1800 both within one frame -> next frame width_us=2300 (last wins); pos_valid on wrap cycle -> applied one frame later.
- SERVO_PWM_SLEW_EN, pos=2000 from center -> width_us 1520, 1540, ... reaching 2500 after 50 frames.
- rst_n asserted at us_cnt=700 while pwm_out high -> pwm_out 0 immediately; after release, width_us=1500 and a fresh frame begins.
